mul_rs_pipe: RTL and testbench

Parametrised multiply reservation station with a pipelined multiplier for the Tomasulo SPARC core. It holds ENTRIES issued UMUL/SMUL(cc) instructions, snoops the CDB for missing operands, and dispatches one ready entry per cycle into a MUL_LAT-stage multiplier. Completed results wait in their entry until the CDB arbiter grants them. It sits between the issue stage and the CDB arbiter, alongside the other functional-unit reservation stations.

---
 rtl/mul_rs_pkg.sv | 36 +++
 rtl/mul_pipe.sv | 66 ++++++
 rtl/mul_rs_pipe.sv | 189 ++++++++++++++++++
 tb/tb_mul_rs_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_rs_pkg.sv
// Shared definitions for the multiply reservation station: opcodes, the
// invalid-tag marker, entry states and the per-entry control record.
package mul_rs_pkg;

  localparam logic [5:0] UMUL    = 6'b001010;
  localparam logic [5:0] SMUL    = 6'b001011;
  localparam logic [5:0] UMUL_CC = 6'b011010;
  localparam logic [5:0] SMUL_CC = 6'b011011;

  localparam int OP_SIGNED_BIT = 0;
  localparam int OP_CC_BIT     = 4;

  // Wide enough for any supported tag width; users slice the low TAG_W bits.
  localparam int MAX_TAG_W = 16;
  localparam logic [MAX_TAG_W-1:0] INVALID_TAG = '1;

  typedef enum logic [2:0] {
    ST_FREE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READY = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } ent_state_t;

  typedef struct packed {
    ent_state_t state;
    logic       is_signed;
    logic       set_cc;
  } ent_ctrl_t;

  // {c, v, z, n}; multiplies never set carry or overflow.
  function automatic logic [3:0] mul_icc(input logic n, input logic z);
    return {2'b00, z, n};
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// MUL_LAT-stage signed/unsigned multiplier carrying a valid bit and the
// originating station index alongside each product.
module mul_pipe #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4,
  parameter int IDX_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                in_signed,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [IDX_W-1:0]    in_idx,
  output logic                out_valid,
  output logic [IDX_W-1:0]    out_idx,
  output logic [2*DATA_W-1:0] out_prod
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod_c;

  // Extending to full product width makes one modular multiply serve both
  // signednesses.
  always_comb begin
    a_ext  = {{DATA_W{in_signed & in_a[DATA_W-1]}}, in_a};
    b_ext  = {{DATA_W{in_signed & in_b[DATA_W-1]}}, in_b};
    prod_c = a_ext * b_ext;
  end

  for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_stage
    logic                v_in;
    logic [IDX_W-1:0]    idx_in;
    logic [2*DATA_W-1:0] prod_in;
    logic                v_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [2*DATA_W-1:0] prod_reg;

    if (gi == 0) begin : g_src
      assign v_in    = in_valid;
      assign idx_in  = in_idx;
      assign prod_in = prod_c;
    end else begin : g_src
      assign v_in    = g_stage[gi-1].v_reg;
      assign idx_in  = g_stage[gi-1].idx_reg;
      assign prod_in = g_stage[gi-1].prod_reg;
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        v_reg <= 1'b0;
      end else begin
        v_reg <= v_in;
      end
      idx_reg  <= idx_in;
      prod_reg <= prod_in;
    end
  end

  assign out_valid = g_stage[MUL_LAT-1].v_reg;
  assign out_idx   = g_stage[MUL_LAT-1].idx_reg;
  assign out_prod  = g_stage[MUL_LAT-1].prod_reg;

endmodule

// File: rtl/mul_rs_pipe.sv
// Multiply reservation station: allocates entries on issue, snoops the CDB,
// dispatches one ready entry per cycle into mul_pipe and presents results.
module mul_rs_pipe
  import mul_rs_pkg::*;
#(
  parameter int ENTRIES  = 4,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int MUL_LAT  = 4,
  parameter int TAG_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [5:0]        issue_op,
  input  logic [TAG_W-1:0]  issue_tag1,
  input  logic [TAG_W-1:0]  issue_tag2,
  input  logic [DATA_W-1:0] issue_val1,
  input  logic [DATA_W-1:0] issue_val2,
  output logic [TAG_W-1:0]  issue_rs_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_val,
  output logic [DATA_W-1:0] out_y,
  output logic [3:0]        out_icc,
  output logic              out_icc_we
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [TAG_W-1:0] INV_TAG = INVALID_TAG[TAG_W-1:0];

  typedef struct packed {
    ent_ctrl_t             ctrl;
    logic [TAG_W-1:0]      tag1;
    logic [TAG_W-1:0]      tag2;
    logic [DATA_W-1:0]     val1;
    logic [DATA_W-1:0]     val2;
    logic [2*DATA_W-1:0]   prod;
  } entry_t;

  entry_t ent_reg  [ENTRIES];
  entry_t ent_next [ENTRIES];

  logic             free_any, rdy_any, done_any;
  logic [IDX_W-1:0] alloc_idx, disp_idx, cmp_idx;
  logic             issue_fire;
  logic             fwd1, fwd2;
  entry_t           disp_ent, cmp_ent;

  logic                pipe_valid;
  logic [IDX_W-1:0]    pipe_idx;
  logic [2*DATA_W-1:0] pipe_prod;

  logic unused_op_bits;
  assign unused_op_bits = ^{issue_op[5], issue_op[3:1]};

  // Scanning downwards leaves the lowest matching index in each picker.
  always_comb begin
    free_any  = 1'b0;
    rdy_any   = 1'b0;
    done_any  = 1'b0;
    alloc_idx = '0;
    disp_idx  = '0;
    cmp_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_reg[i].ctrl.state == ST_FREE) begin
        free_any  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (ent_reg[i].ctrl.state == ST_READY) begin
        rdy_any  = 1'b1;
        disp_idx = IDX_W'(i);
      end
      if (ent_reg[i].ctrl.state == ST_DONE) begin
        done_any = 1'b1;
        cmp_idx  = IDX_W'(i);
      end
    end
  end

  assign issue_ready  = free_any;
  assign issue_fire   = issue_valid & free_any;
  assign issue_rs_tag = TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);
  assign fwd1 = cdb_valid && (issue_tag1 != INV_TAG) && (issue_tag1 == cdb_tag);
  assign fwd2 = cdb_valid && (issue_tag2 != INV_TAG) && (issue_tag2 == cdb_tag);
  assign disp_ent = ent_reg[disp_idx];
  assign cmp_ent  = ent_reg[cmp_idx];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_next[i] = ent_reg[i];
      unique case (ent_reg[i].ctrl.state)
        ST_FREE: begin
          if (issue_fire && alloc_idx == IDX_W'(i)) begin
            ent_next[i].ctrl.is_signed = issue_op[OP_SIGNED_BIT];
            ent_next[i].ctrl.set_cc    = issue_op[OP_CC_BIT];
            ent_next[i].tag1 = fwd1 ? INV_TAG : issue_tag1;
            ent_next[i].tag2 = fwd2 ? INV_TAG : issue_tag2;
            ent_next[i].val1 = fwd1 ? cdb_val : issue_val1;
            ent_next[i].val2 = fwd2 ? cdb_val : issue_val2;
            ent_next[i].ctrl.state =
              (ent_next[i].tag1 == INV_TAG && ent_next[i].tag2 == INV_TAG) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cdb_valid && ent_reg[i].tag1 != INV_TAG && ent_reg[i].tag1 == cdb_tag) begin
            ent_next[i].tag1 = INV_TAG;
            ent_next[i].val1 = cdb_val;
          end
          if (cdb_valid && ent_reg[i].tag2 != INV_TAG && ent_reg[i].tag2 == cdb_tag) begin
            ent_next[i].tag2 = INV_TAG;
            ent_next[i].val2 = cdb_val;
          end
          if (ent_next[i].tag1 == INV_TAG && ent_next[i].tag2 == INV_TAG) begin
            ent_next[i].ctrl.state = ST_READY;
          end
        end
        ST_READY: begin
          if (rdy_any && disp_idx == IDX_W'(i)) begin
            ent_next[i].ctrl.state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (pipe_valid && pipe_idx == IDX_W'(i)) begin
            ent_next[i].prod       = pipe_prod;
            ent_next[i].ctrl.state = ST_DONE;
          end
        end
        ST_DONE: begin
          if (cdb_grant && done_any && cmp_idx == IDX_W'(i)) begin
            ent_next[i].ctrl.state = ST_FREE;
          end
        end
        default: ent_next[i].ctrl.state = ST_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_reg[i] <= '0;
      end
    end else begin
      ent_reg <= ent_next;
    end
  end

  mul_pipe #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT),
    .IDX_W   (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (rdy_any),
    .in_signed (disp_ent.ctrl.is_signed),
    .in_a      (disp_ent.val1),
    .in_b      (disp_ent.val2),
    .in_idx    (disp_idx),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx),
    .out_prod  (pipe_prod)
  );

  always_comb begin
    cdb_req    = done_any;
    out_tag    = '0;
    out_val    = '0;
    out_y      = '0;
    out_icc    = '0;
    out_icc_we = 1'b0;
    if (done_any) begin
      out_tag    = TAG_W'(TAG_BASE) + TAG_W'(cmp_idx);
      out_val    = cmp_ent.prod[DATA_W-1:0];
      out_y      = cmp_ent.prod[2*DATA_W-1:DATA_W];
      out_icc    = mul_icc(cmp_ent.prod[DATA_W-1], cmp_ent.prod[DATA_W-1:0] == '0);
      out_icc_we = cmp_ent.ctrl.set_cc;
    end
  end

endmodule

// File: tb/tb_mul_rs_pipe.sv
// Bench for mul_rs_pipe: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a timestamp-based entry model.
`timescale 1ns/1ps
module tb_mul_rs_pipe;
  import mul_rs_pkg::*;

  localparam int ENTRIES  = 4;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int MUL_LAT  = 4;
  localparam int TAG_BASE = 8;
  localparam logic [TAG_W-1:0] INV = 5'h1f;

  logic clk = 1'b0;
  logic rst, flush, issue_valid, issue_ready, cdb_valid, cdb_req, cdb_grant, out_icc_we;
  logic [5:0]        issue_op;
  logic [TAG_W-1:0]  issue_tag1, issue_tag2, issue_rs_tag, cdb_tag, out_tag;
  logic [DATA_W-1:0] issue_val1, issue_val2, cdb_val, out_val, out_y;
  logic [3:0]        out_icc;

  always #5 clk = ~clk;

  mul_rs_pipe #(
    .ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .TAG_BASE(TAG_BASE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
    .issue_val1(issue_val1), .issue_val2(issue_val2), .issue_rs_tag(issue_rs_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .out_tag(out_tag), .out_val(out_val), .out_y(out_y),
    .out_icc(out_icc), .out_icc_we(out_icc_we)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an occupied entry holds operands (or the tag it awaits); once
  // dispatched it is known to finish at a fixed cycle number.
  typedef struct {
    bit          busy;
    bit          disp;
    int          done_at;
    bit          h1, h2;
    logic [4:0]  t1, t2;
    logic [31:0] v1, v2;
    logic [5:0]  op;
  } ment_t;

  ment_t m [ENTRIES];
  int now = 0;

  function automatic logic [63:0] ref_prod(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    if (op[0]) return sa * sb;
    return ua * ub;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < ENTRIES; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int first_done();
    for (int i = 0; i < ENTRIES; i++)
      if (m[i].busy && m[i].disp && now >= m[i].done_at) return i;
    return -1;
  endfunction

  function automatic int first_ready();
    for (int i = 0; i < ENTRIES; i++)
      if (m[i].busy && !m[i].disp && m[i].h1 && m[i].h2) return i;
    return -1;
  endfunction

  task automatic model_check();
    int fi, di;
    logic [63:0] p;
    logic [3:0]  ei;
    fi = first_free();
    di = first_done();
    chk("issue_ready", issue_ready, fi >= 0);
    if (fi >= 0) chk("issue_rs_tag", issue_rs_tag, TAG_BASE + fi);
    chk("cdb_req", cdb_req, di >= 0);
    if (di >= 0) begin
      p  = ref_prod(m[di].op, m[di].v1, m[di].v2);
      ei = {2'b00, p[31:0] == 32'd0, p[31]};
      chk("out_tag", out_tag, TAG_BASE + di);
      chk("out_val", out_val, p[31:0]);
      chk("out_y", out_y, p[63:32]);
      chk("out_icc", out_icc, ei);
      chk("out_icc_we", out_icc_we, m[di].op[4]);
    end else begin
      chk("idle out_icc_we", out_icc_we, 1'b0);
    end
  endtask

  task automatic model_step();
    int fi, di, ri;
    if (rst || flush) begin
      for (int i = 0; i < ENTRIES; i++) m[i].busy = 0;
      return;
    end
    fi = first_free();
    di = first_done();
    ri = first_ready();
    if (ri >= 0) begin
      m[ri].disp    = 1;
      m[ri].done_at = now + MUL_LAT + 1;
    end
    if (cdb_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (m[i].busy && !m[i].h1 && m[i].t1 == cdb_tag) begin m[i].h1 = 1; m[i].v1 = cdb_val; end
        if (m[i].busy && !m[i].h2 && m[i].t2 == cdb_tag) begin m[i].h2 = 1; m[i].v2 = cdb_val; end
      end
    end
    if (issue_valid && fi >= 0) begin
      m[fi].busy = 1;
      m[fi].disp = 0;
      m[fi].op   = issue_op;
      m[fi].t1   = issue_tag1;
      m[fi].t2   = issue_tag2;
      m[fi].h1   = (issue_tag1 == INV) || (cdb_valid && cdb_tag == issue_tag1);
      m[fi].h2   = (issue_tag2 == INV) || (cdb_valid && cdb_tag == issue_tag2);
      m[fi].v1   = (issue_tag1 == INV) ? issue_val1 : cdb_val;
      m[fi].v2   = (issue_tag2 == INV) ? issue_val2 : cdb_val;
    end
    if (di >= 0 && cdb_grant) begin
      $display("xact cycle=%0d tag=%0d a=%h b=%h op=%b prod=%h", now, TAG_BASE + di,
               m[di].v1, m[di].v2, m[di].op, ref_prod(m[di].op, m[di].v1, m[di].v2));
      m[di].busy = 0;
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_check();
      model_step();
      now++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] t1, input logic [4:0] t2,
                       input logic [31:0] v1, input logic [31:0] v2);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_tag1  = t1;
    issue_tag2  = t2;
    issue_val1  = v1;
    issue_val2  = v2;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!cdb_req && n < 30) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [4:0] pick_tag();
    logic [4:0] srcs [7];
    srcs = '{5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11};
    if ($urandom_range(0, 9) < 6) return INV;
    return srcs[$urandom_range(0, 6)];
  endfunction

  int  n;
  bit  seen;
  logic [5:0] ops [4];

  initial begin
    ops = '{UMUL, SMUL, UMUL_CC, SMUL_CC};
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_op = UMUL;
    issue_tag1 = INV; issue_tag2 = INV; issue_val1 = '0; issue_val2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_grant = 1'b0;
    tick();
    tick();
    chk("rst issue_ready", issue_ready, 1'b1);
    chk("rst cdb_req", cdb_req, 1'b0);
    chk("rst out_icc_we", out_icc_we, 1'b0);
    chk("rst out_tag", out_tag, 0);
    chk("rst out_val", out_val, 0);
    chk("rst out_y", out_y, 0);
    chk("rst out_icc", out_icc, 0);
    chk("rst issue_rs_tag", issue_rs_tag, 8);
    rst = 1'b0;

    // 7 x 6 unsigned, grant held high.
    cdb_grant = 1'b1;
    issue(UMUL, INV, INV, 32'd7, 32'd6);
    wait_req(n);
    chk("umul latency", n, 5);
    chk("umul val", out_val, 42);
    chk("umul y", out_y, 0);
    chk("umul tag", out_tag, 8);
    chk("umul icc_we", out_icc_we, 0);
    tick();
    chk("umul drained", cdb_req, 0);

    // -3 x 5 signed with condition codes.
    issue(SMUL_CC, INV, INV, 32'hFFFF_FFFD, 32'd5);
    wait_req(n);
    chk("smul latency", n, 5);
    chk("smul val", out_val, 32'hFFFF_FFF1);
    chk("smul y", out_y, 32'hFFFF_FFFF);
    chk("smul icc", out_icc, 4'b0001);
    chk("smul icc_we", out_icc_we, 1);
    tick();

    // Wakeup on tag 3, and same-cycle forwarding into a second issue.
    issue(UMUL, 5'd3, INV, 32'd0, 32'd2);
    tick();
    tick();
    chk("waiting no req", cdb_req, 0);
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_val = 32'd9;
    issue(UMUL, 5'd3, INV, 32'd0, 32'd5);
    cdb_valid = 1'b0;
    wait_req(n);
    chk("wake latency", n, 5);
    chk("wake val", out_val, 18);
    chk("wake tag", out_tag, 8);
    tick();
    chk("fwd req", cdb_req, 1);
    chk("fwd tag", out_tag, 9);
    chk("fwd val", out_val, 45);
    tick();
    chk("fwd drained", cdb_req, 0);

    // Fill with stalled operands, hold results, then drain lowest first.
    cdb_grant = 1'b0;
    issue_valid = 1'b1; issue_op = UMUL; issue_tag1 = 5'd20; issue_tag2 = INV;
    for (int i = 0; i < ENTRIES; i++) begin
      issue_val2 = 32'(i + 1);
      tick();
    end
    issue_valid = 1'b0;
    chk("full ready", issue_ready, 0);
    issue(UMUL, INV, INV, 32'd100, 32'd100);
    chk("full ignored", issue_ready, 0);
    cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_val = 32'd3;
    tick();
    cdb_valid = 1'b0;
    repeat (MUL_LAT + ENTRIES + 1) tick();
    for (int k = 0; k < 3; k++) begin
      chk("hold req", cdb_req, 1);
      chk("hold tag", out_tag, 8);
      chk("hold val", out_val, 3);
      tick();
    end
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    chk("regain ready", issue_ready, 1);
    chk("drain tag 9", out_tag, 9);
    chk("drain val 6", out_val, 6);
    cdb_grant = 1'b1;
    tick();
    chk("drain tag 10", out_tag, 10);
    chk("drain val 9", out_val, 9);
    tick();
    chk("drain tag 11", out_tag, 11);
    chk("drain val 12", out_val, 12);
    tick();
    chk("drain empty", cdb_req, 0);

    // Flush with one entry executing and two waiting.
    cdb_grant = 1'b0;
    issue(UMUL, INV, INV, 32'd11, 32'd12);
    issue(UMUL, 5'd21, INV, 32'd0, 32'd1);
    issue(SMUL, 5'd21, INV, 32'd0, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush ready", issue_ready, 1);
    chk("flush rs_tag", issue_rs_tag, 8);
    cdb_valid = 1'b1; cdb_tag = 5'd21; cdb_val = 32'd4;
    tick();
    cdb_valid = 1'b0;
    seen = 0;
    repeat (MUL_LAT + 4) begin
      tick();
      if (cdb_req) seen = 1;
    end
    chk("flush no req", seen, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rst         = ($urandom_range(0, 399) == 0);
      flush       = ($urandom_range(0, 149) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_op    = ops[$urandom_range(0, 3)];
      issue_tag1  = pick_tag();
      issue_tag2  = pick_tag();
      issue_val1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      issue_val2  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      cdb_valid   = ($urandom_range(0, 2) == 0);
      cdb_tag     = pick_tag();
      if (cdb_tag == INV) cdb_tag = 5'd2;
      cdb_val     = $urandom;
      cdb_grant   = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; cdb_valid = 1'b0; cdb_grant = 1'b1;
    repeat (MUL_LAT + ENTRIES + 4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
